// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
//   Shared definitions for the pipelined bitwise logic unit.
//   - LOGIC_OP_W : width of the operation select field
//   - logic_op_e : operation encoding used on the op port
//   - logic_bit  : single-bit evaluation of one operation; the core applies it
//                  independently to every bit position
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } logic_op_e;

  // One bit of the selected operation. Every op is purely bitwise, so the
  // full-width result is just this function replicated across the word.
  function automatic logic logic_bit(input logic_op_e op, input logic x, input logic y);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_ANDN: r = x & ~y;
      OP_PASS: r = x;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// ---------------------------------------------------------------------------
// logic_unit_core
//   Purely combinational W-bit bitwise logic unit.
//   Ports:
//     op  in  logic_op_e  operation select
//     a   in  W           operand A
//     b   in  W           operand B
//     r   out W           f(op, a, b), bitwise, no carries
// ---------------------------------------------------------------------------
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic_op_e      op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   r
);

  // Each result bit depends only on the matching operand bits.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign r[gi] = logic_bit(op, a[gi], b[gi]);
    end
  endgenerate

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Two-stage pipelined W-bit bitwise logic unit with valid/ready flow
//   control and a wrapping count of completed output handshakes.
//   S1 registers a/b/op; S2 registers the computed result.
//
//   Optional build macro: LOGIC_UNIT_FLAGS_EN
//     When defined, y_zero / y_ones ports exist and are registered with y.
//
//   Ports:
//     clk        in   1        clock, rising edge
//     rst        in   1        synchronous reset, active-high
//     in_valid   in   1        operand beat valid
//     in_ready   out  1        unit can accept a beat this cycle
//     a, b       in   W        operands
//     op         in   3        operation (logic_op_e encoding)
//     out_valid  out  1        result valid
//     out_ready  in   1        downstream accepts result
//     y          out  W        result
//     txn_count  out  COUNT_W  completed output handshakes, wraps
//     y_zero     out  1        y == 0          (flags build only)
//     y_ones     out  1        y == all ones   (flags build only)
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int W       = 8,
  parameter int COUNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [LOGIC_OP_W-1:0] op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          y,
  output logic [COUNT_W-1:0]    txn_count
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic                  y_zero,
  output logic                  y_ones
`endif
);

  // Stage 1: captured operands
  logic              s1_valid_reg;
  logic [W-1:0]      s1_a_reg;
  logic [W-1:0]      s1_b_reg;
  logic_op_e         s1_op_reg;

  // Stage 2: registered result
  logic              s2_valid_reg;
  logic [W-1:0]      y_reg;
  logic [COUNT_W-1:0] count_reg;

  logic [W-1:0]      core_r;
  logic              s2_adv;
  logic              s1_adv;
  logic              emit;

  // A stage may load when it is empty or its contents move on this cycle.
  // in_ready is therefore combinational from out_ready (no skid buffer).
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign emit     = s2_valid_reg && out_ready;

  logic_unit_core #(
    .W (W)
  ) u_core (
    .op (s1_op_reg),
    .a  (s1_a_reg),
    .b  (s1_b_reg),
    .r  (core_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= OP_AND;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      // Operands only change on an actual accept so S1 data stays tidy
      // while the stage is empty.
      if (in_valid) begin
        s1_a_reg  <= a;
        s1_b_reg  <= b;
        s1_op_reg <= logic_op_e'(op);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      y_reg        <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      // y keeps its last value across bubbles; only a real beat updates it.
      if (s1_valid_reg) begin
        y_reg <= core_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (emit) begin
      count_reg <= count_reg + COUNT_W'(1);
    end
  end

  assign out_valid = s2_valid_reg;
  assign y         = y_reg;
  assign txn_count = count_reg;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic y_zero_reg;
  logic y_ones_reg;

  // Flags are computed from the same core result and loaded under the same
  // condition as y, so they share its timing exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_zero_reg <= 1'b0;
      y_ones_reg <= 1'b0;
    end else if (s2_adv && s1_valid_reg) begin
      y_zero_reg <= (core_r == '0);
      y_ones_reg <= (core_r == '1);
    end
  end

  assign y_zero = y_zero_reg;
  assign y_ones = y_ones_reg;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe (W=8). A second instance with
//   COUNT_W=2 shares all inputs so counter wrap is exercised alongside.
//   Reference model: a queue of in-flight results, each tagged with the
//   number of clock edges since it was accepted.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [15:0] txn_count;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] y2;
  logic [1:0] txn_count2;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic y_zero, y_ones, y_zero2, y_ones2;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.W(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .txn_count(txn_count)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .y_zero(y_zero), .y_ones(y_ones)
`endif
  );

  logic_unit_pipe #(.W(8), .COUNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .txn_count(txn_count2)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .y_zero(y_zero2), .y_ones(y_ones2)
`endif
  );

  int checks_total = 0;
  int checks_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] ref_op(input int o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      0: return x & z;
      1: return x | z;
      2: return x ^ z;
      3: return ~(x & z);
      4: return ~(x | z);
      5: return ~(x ^ z);
      6: return x & ~z;
      default: return x;
    endcase
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [7:0] q_r[$];
  int         q_age[$];
  int         m_cnt = 0;
  bit         started = 0;
  bit         prev_emit = 0;
  bit         wrap_arm = 0;
  int         wrap_n = 0;
  logic [1:0] wrap_seen[5];

  always @(negedge clk) begin
    bit m_ir, m_ov, acc, emit;
    m_ir = (q_r.size() < 2) || out_ready;
    m_ov = (q_r.size() > 0) && (q_age[0] >= 1);
    if (started) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ir});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        chk("y", {24'b0, y}, {24'b0, q_r[0]});
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("y_zero", {31'b0, y_zero}, {31'b0, (q_r[0] == 8'h00)});
        chk("y_ones", {31'b0, y_ones}, {31'b0, (q_r[0] == 8'hFF)});
`endif
      end
      chk("txn_count", {16'b0, txn_count}, m_cnt % 65536);
      chk("txn_count_w2", {30'b0, txn_count2}, m_cnt % 4);
    end
    if (prev_emit && wrap_arm && wrap_n < 5) begin
      wrap_seen[wrap_n] = txn_count2;
      wrap_n++;
    end
    emit = 0;
    if (rst) begin
      q_r.delete();
      q_age.delete();
      m_cnt   = 0;
      wrap_n  = 0;
      started = 1;
    end else begin
      emit = m_ov && out_ready;
      acc  = in_valid && m_ir;
      if (emit) begin
        void'(q_r.pop_front());
        void'(q_age.pop_front());
        m_cnt++;
      end
      foreach (q_age[i]) q_age[i]++;
      if (acc) begin
        q_r.push_back(ref_op(int'(op), a, b));
        q_age.push_back(0);
      end
    end
    prev_emit = emit;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] lit[8];
  logic [1:0] wexp[5];

  initial begin
    logic [7:0] y_hold;
    int ir_low;
    bit took;
    lit  = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'h82, 8'hCA};
    wexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    tick();
    tick();
    rst = 1'b0;
    // reset state, first cycle after reset release
    chk("rst_y", {24'b0, y}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_txn", {16'b0, txn_count}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // per-op sweep with fixed operands
    for (int i = 0; i < 8; i++) begin
      a = 8'hCA; b = 8'h5C; op = 3'(i); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("sweep_model", {24'b0, ref_op(i, 8'hCA, 8'h5C)}, {24'b0, lit[i]});
      chk("sweep_y", {24'b0, y}, {24'b0, lit[i]});
      chk("sweep_valid", {31'b0, out_valid}, 32'h1);
    end
    tick();

    // streaming 16 back-to-back beats; wrap instance records its count
    do_reset();
    wrap_arm = 1;
    ir_low = 0;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) ir_low++;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    wrap_arm = 0;
    chk("stream_in_ready_low", ir_low, 0);
    chk("stream_txn", {16'b0, txn_count}, 32'd16);
    chk("wrap_n", wrap_n, 5);
    for (int i = 0; i < 5; i++) chk("wrap_seq", {30'b0, wrap_seen[i]}, {30'b0, wexp[i]});

    // backpressure: two beats fill the pipe, third is held by the source
    out_ready = 1'b0;
    a = 8'h11; b = 8'h0F; op = 3'd2; in_valid = 1'b1; tick();
    a = 8'h22; b = 8'hF0; op = 3'd1; tick();
    a = 8'h33; b = 8'h33; op = 3'd7;
    chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
    chk("bp_y_first", {24'b0, y}, 32'h1E);
    y_hold = y;
    repeat (3) begin
      tick();
      chk("bp_y_hold", {24'b0, y}, {24'b0, y_hold});
      chk("bp_valid_hold", {31'b0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_y_second", {24'b0, y}, 32'hF2);
    repeat (4) tick();

    // reset mid-flight
    out_ready = 1'b0;
    a = 8'h0F; b = 8'hFF; op = 3'd0; in_valid = 1'b1; tick();
    a = 8'hF0; tick();
    in_valid = 1'b0;
    do_reset();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_txn", {16'b0, txn_count}, 32'h0);
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      chk("mid_rst_stale", {31'b0, out_valid}, 32'h0);
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    a = 8'h3C; b = 8'h3C; op = 3'd2; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("flag_xor_y", {24'b0, y}, 32'h00);
    chk("flag_xor_zero", {31'b0, y_zero}, 32'h1);
    a = 8'h00; b = 8'h00; op = 3'd4; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("flag_nor_y", {24'b0, y}, 32'hFF);
    chk("flag_nor_ones", {31'b0, y_ones}, 32'h1);
    tick();
`endif

    // randomized traffic; a beat not taken is held unchanged
    took = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      took = (in_valid && in_ready) || rst;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
